// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm-clock controller. It holds a settable alarm time and
// compares it with the timekeeper's time on each one-second tick while armed.
// On a match it rings for RING_SEC ticks. Up to MAX_SNOOZE snoozes of
// SNOOZE_SEC ticks each are allowed per alarm event.
//
// Ports
//   clk, clr                 clock, synchronous active-high reset
//   tick                     one-cycle strobe per second; hr/min/sec valid then
//   hr, min, sec             current time
//   arm_en                   level: 1 arms, 0 forces IDLE
//   set_en, set_hr/min/sec   one-cycle alarm-time load request and data
//   stop, snooze             one-cycle button pulses
//   alarm                    registered, 1 while ringing
//   state                    FSM state (IDLE=0 ARMED=1 RINGING=2 SNOOZE=3)
//   alm_hr/min/sec           stored alarm time
//   set_err                  one-cycle pulse when a set request is rejected
//
// Handshake: there is no valid/ready flow control. Every input pulse
// (tick, set_en, stop, snooze) is consumed on the edge where it is high and
// is never held off or queued.
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic [7:0] hr,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic       arm_en,
  input  logic       set_en,
  input  logic [7:0] set_hr,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  input  logic       stop,
  input  logic       snooze,
  output logic       alarm,
  output logic [1:0] state,
  output logic [7:0] alm_hr,
  output logic [7:0] alm_min,
  output logic [7:0] alm_sec,
  output logic       set_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  localparam logic [15:0] RING_LAST   = 16'(RING_SEC - 1);
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
  localparam logic [7:0]  SNOOZE_MAX  = 8'(MAX_SNOOZE);

  state_t      state_q, state_d;
  logic [15:0] ring_cnt_q, ring_cnt_d;
  logic [15:0] snz_cnt_q, snz_cnt_d;
  logic [7:0]  snz_num_q, snz_num_d;
  logic [7:0]  alm_hr_q, alm_hr_d;
  logic [7:0]  alm_min_q, alm_min_d;
  logic [7:0]  alm_sec_q, alm_sec_d;
  logic        set_err_q, set_err_d;
  logic        alarm_q;

  logic match;
  logic set_ok;

  // The match compares against the stored (old) alarm time even when a set
  // lands on the same cycle; the new time only takes effect after the edge.
  assign match  = tick && (hr == alm_hr_q) && (min == alm_min_q) && (sec == alm_sec_q);
  assign set_ok = (set_hr <= 8'd23) && (set_min <= 8'd59) && (set_sec <= 8'd59) &&
                  ((state_q == IDLE) || (state_q == ARMED));

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    snz_num_d  = snz_num_q;
    alm_hr_d   = alm_hr_q;
    alm_min_d  = alm_min_q;
    alm_sec_d  = alm_sec_q;
    set_err_d  = 1'b0;

    if (set_en) begin
      if (set_ok) begin
        alm_hr_d  = set_hr;
        alm_min_d = set_min;
        alm_sec_d = set_sec;
      end else begin
        set_err_d = 1'b1;
      end
    end

    if (!arm_en) begin
      state_d    = IDLE;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
      snz_num_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (match) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
            snz_num_d  = '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = ARMED;
          end else if (snooze) begin
            // Once the snooze allowance is used up, snooze behaves as stop.
            if (snz_num_q < SNOOZE_MAX) begin
              state_d   = SNOOZE;
              snz_num_d = snz_num_q + 8'd1;
              snz_cnt_d = '0;
            end else begin
              state_d = ARMED;
            end
          end else if (tick) begin
            if (ring_cnt_q == RING_LAST) state_d = ARMED;
            else                         ring_cnt_d = ring_cnt_q + 16'd1;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = ARMED;
          end else if (tick) begin
            if (snz_cnt_q == SNOOZE_LAST) begin
              state_d    = RINGING;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      snz_num_q  <= '0;
      alm_hr_q   <= '0;
      alm_min_q  <= '0;
      alm_sec_q  <= '0;
      set_err_q  <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      snz_num_q  <= snz_num_d;
      alm_hr_q   <= alm_hr_d;
      alm_min_q  <= alm_min_d;
      alm_sec_q  <= alm_sec_d;
      set_err_q  <= set_err_d;
      // Registered copy of the next state so alarm tracks state exactly.
      alarm_q    <= (state_d == RINGING);
    end
  end

  assign alarm   = alarm_q;
  assign state   = state_q;
  assign alm_hr  = alm_hr_q;
  assign alm_min = alm_min_q;
  assign alm_sec = alm_sec_q;
  assign set_err = set_err_q;

endmodule
